// File: rtl/nios_soc_mem_engine.sv
// nios_soc_mem_engine
// Avalon-MM master that runs one memory command at a time against a
// single-port on-chip RAM: FILL a word range with a constant or incrementing
// pattern, SUM a word range, or VERIFY a word range against a pattern.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op              0=FILL 1=SUM 2=VERIFY 3=reserved
//   cmd_base/count      first word address / number of words (clamped)
//   cmd_pattern/incr    fill/compare seed, +1 per word when incr is set
//   busy, done          command in progress / one-cycle completion pulse
//   result              FILL: words written, SUM: sum, VERIFY: words checked
//   error, err_addr     VERIFY mismatch or reserved op / first bad address
//   avm_*               Avalon-MM master port
module nios_soc_mem_engine #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic [31:0]       cmd_pattern,
    input  logic              cmd_incr,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        OP_FILL   = 2'd0,
        OP_SUM    = 2'd1,
        OP_VERIFY = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    localparam logic [ADDR_W:0] IDX_ONE  = 1;
    localparam logic [2:0]      LAT_INIT = 3'(READ_LATENCY);

    state_e            state;
    op_e               op_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   count_r;
    logic [31:0]       pattern_r;
    logic              incr_r;
    logic [ADDR_W:0]   index;
    logic [2:0]        lat_cnt;

    logic [ADDR_W:0]   cnt_clamp;
    logic [ADDR_W:0]   next_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       cur_pat;
    logic [31:0]       next_pat;
    logic              last;

    always_comb begin
        cnt_clamp = cmd_count;
        if (cmd_count[ADDR_W]) begin
            cnt_clamp = {1'b1, {ADDR_W{1'b0}}};
        end
        next_idx  = index + IDX_ONE;
        cur_addr  = base_r + index[ADDR_W-1:0];
        next_addr = base_r + next_idx[ADDR_W-1:0];
        cur_pat   = incr_r ? (pattern_r + 32'(index)) : pattern_r;
        next_pat  = incr_r ? (pattern_r + 32'(next_idx)) : pattern_r;
        last      = (next_idx == count_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            op_r           <= OP_FILL;
            base_r         <= '0;
            count_r        <= '0;
            pattern_r      <= '0;
            incr_r         <= 1'b0;
            index          <= '0;
            lat_cnt        <= '0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            error          <= 1'b0;
            err_addr       <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        op_r      <= op_e'(cmd_op);
                        base_r    <= cmd_base;
                        count_r   <= cnt_clamp;
                        pattern_r <= cmd_pattern;
                        incr_r    <= cmd_incr;
                        index     <= '0;
                        result    <= '0;
                        error     <= 1'b0;
                        err_addr  <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (op_e'(cmd_op) == OP_RSVD) begin
                            error <= 1'b1;
                            state <= S_FINISH;
                        end else if (cnt_clamp == '0) begin
                            state <= S_FINISH;
                        end else if (op_e'(cmd_op) == OP_FILL) begin
                            state          <= S_WR;
                            avm_write      <= 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_byteenable <= '1;
                            avm_address    <= cmd_base;
                            avm_writedata  <= cmd_pattern;
                        end else begin
                            state          <= S_RD_REQ;
                            avm_read       <= 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_byteenable <= '1;
                            avm_address    <= cmd_base;
                        end
                    end
                end

                S_WR: begin
                    if (!avm_waitrequest) begin
                        index  <= next_idx;
                        result <= result + 32'd1;
                        if (last) begin
                            avm_write      <= 1'b0;
                            avm_chipselect <= 1'b0;
                            avm_byteenable <= '0;
                            state          <= S_FINISH;
                        end else begin
                            avm_address   <= next_addr;
                            avm_writedata <= next_pat;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read       <= 1'b0;
                        avm_chipselect <= 1'b0;
                        avm_byteenable <= '0;
                        lat_cnt        <= LAT_INIT;
                        state          <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    // Counter was loaded at the accept edge, so data is valid
                    // on the edge where it reads 1.
                    if (lat_cnt == 3'd1) begin
                        if (op_r == OP_SUM) begin
                            result <= result + avm_readdata;
                        end else begin
                            result <= result + 32'd1;
                        end
                        if (op_r == OP_VERIFY && avm_readdata != cur_pat) begin
                            error    <= 1'b1;
                            err_addr <= cur_addr;
                            state    <= S_FINISH;
                        end else begin
                            index <= next_idx;
                            if (last) begin
                                state <= S_FINISH;
                            end else begin
                                state          <= S_RD_REQ;
                                avm_read       <= 1'b1;
                                avm_chipselect <= 1'b1;
                                avm_byteenable <= '1;
                                avm_address    <= next_addr;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                S_FINISH: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
